// File: rtl/eth_rx_frame_writer_if.sv
// eth_rx_frame_writer_if: MAC RX beat stream in, frame queue write/confirm/erase port out
interface eth_rx_frame_writer_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8
);
  logic                     s_tvalid;
  logic [DATA_W-1:0]        s_tdata;
  logic [KEEP_W-1:0]        s_tkeep;
  logic                     s_tlast;
  logic                     s_tuser;
  logic                     q_full;
  logic                     q_write;
  logic                     q_confirm;
  logic                     q_erase;
  logic [DATA_W+KEEP_W:0]   q_din;
  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, q_full,
    output q_write, q_confirm, q_erase, q_din
  );
  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, q_full,
    input  q_write, q_confirm, q_erase, q_din
  );
endinterface

// File: rtl/eth_rx_frame_writer.sv
// eth_rx_frame_writer: commits complete error-free MAC RX frames to the frame queue, rolls back the rest
module eth_rx_frame_writer #(
  parameter int DATA_W    = 512,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int MAX_WORDS = 150,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx_enable,
  eth_rx_frame_writer_if.slave bus,
  output logic [CNT_W-1:0]     cnt_good,
  output logic [CNT_W-1:0]     cnt_err,
  output logic [CNT_W-1:0]     cnt_ovf,
  output logic [CNT_W-1:0]     cnt_oversize,
  output logic [CNT_W-1:0]     cnt_disabled
);
  localparam int WC_W = $clog2(MAX_WORDS + 1);
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  state_t            state_q, state_d;
  logic              b_valid_q, b_last_q, b_user_q, b_en_q;
  logic [KEEP_W-1:0] b_keep_q;
  logic [DATA_W-1:0] b_data_q;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              wr, conf, ers;
  logic [4:0]        inc;
  logic [CNT_W-1:0]  cnt_q [5];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      b_valid_q <= 1'b0;
      wc_q      <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      b_valid_q <= bus.s_tvalid;
      wc_q      <= wc_d;
      for (int i = 0; i < 5; i++)
        if (inc[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  // rx_enable travels with the beat so the frame-start decision sees the value present with the first beat
  always_ff @(posedge clk) begin
    b_data_q <= bus.s_tdata;
    b_keep_q <= bus.s_tkeep;
    b_last_q <= bus.s_tlast;
    b_user_q <= bus.s_tuser;
    b_en_q   <= rx_enable;
  end

  // inc bits: 0 good, 1 err, 2 ovf, 3 oversize, 4 disabled
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    wr      = 1'b0;
    conf    = 1'b0;
    ers     = 1'b0;
    inc     = '0;
    if (b_valid_q) begin
      if (state_q == DROP) begin
        state_d = b_last_q ? IDLE : DROP;
      end else if (state_q == IDLE && !b_en_q) begin
        inc[4]  = 1'b1;
        state_d = b_last_q ? IDLE : DROP;
        wc_d    = '0;
      end else if (bus.q_full) begin
        ers     = 1'b1;
        inc[2]  = 1'b1;
        state_d = b_last_q ? IDLE : DROP;
        wc_d    = '0;
      end else if (b_last_q && b_user_q) begin
        ers     = 1'b1;
        inc[1]  = 1'b1;
        state_d = IDLE;
        wc_d    = '0;
      end else if (b_last_q) begin
        wr      = 1'b1;
        conf    = 1'b1;
        inc[0]  = 1'b1;
        state_d = IDLE;
        wc_d    = '0;
      end else if (wc_q == WC_W'(MAX_WORDS - 1)) begin
        ers     = 1'b1;
        inc[3]  = 1'b1;
        state_d = DROP;
        wc_d    = '0;
      end else begin
        wr      = 1'b1;
        state_d = PASS;
        wc_d    = wc_q + 1'b1;
      end
    end
  end

  assign bus.q_write   = rstn & wr;
  assign bus.q_confirm = rstn & conf;
  assign bus.q_erase   = rstn & ers;
  assign bus.q_din     = {b_last_q, b_keep_q, b_data_q};
  assign cnt_good      = cnt_q[0];
  assign cnt_err       = cnt_q[1];
  assign cnt_ovf       = cnt_q[2];
  assign cnt_oversize  = cnt_q[3];
  assign cnt_disabled  = cnt_q[4];
endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// tb_eth_rx_frame_writer: directed and random frames checked against a frame-level outcome model and a queue model
module tb_eth_rx_frame_writer;
  localparam int DW = 32, KW = 4, MW = 4, CW = 4;
  localparam int SATV = (1 << CW) - 1;
  logic clk = 1'b0, rstn = 1'b0, rx_enable = 1'b0;
  logic [CW-1:0] cnt_good, cnt_err, cnt_ovf, cnt_oversize, cnt_disabled;
  eth_rx_frame_writer_if #(.DATA_W(DW), .KEEP_W(KW)) bus();
  eth_rx_frame_writer #(.DATA_W(DW), .KEEP_W(KW), .MAX_WORDS(MW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .rx_enable(rx_enable), .bus(bus),
    .cnt_good(cnt_good), .cnt_err(cnt_err), .cnt_ovf(cnt_ovf),
    .cnt_oversize(cnt_oversize), .cnt_disabled(cnt_disabled)
  );
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_wr = 0, n_er = 0, n_cf = 0, n_viol = 0;
  int e_wr = 0, e_er = 0, e_cf = 0;
  int e_cnt [5] = '{0, 0, 0, 0, 0};
  int prev_idx = -1, full_at = -1;
  logic [DW+KW:0] pend[$], got[$], exp_q[$], frame[$];

  // queue model: erase drops pending words, confirm commits them; rules on strobe combinations
  always @(negedge clk) begin
    if (!rstn) begin
      if (bus.q_write || bus.q_confirm || bus.q_erase) n_viol++;
      pend.delete();
    end else begin
      if (bus.q_write && bus.q_full) n_viol++;
      if (bus.q_write && bus.q_erase) n_viol++;
      if (bus.q_confirm && !bus.q_write) n_viol++;
      if (bus.q_erase) begin n_er++; pend.delete(); end
      if (bus.q_write) begin n_wr++; pend.push_back(bus.q_din); end
      if (bus.q_confirm) begin
        n_cf++;
        foreach (pend[i]) got.push_back(pend[i]);
        pend.delete();
      end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic bump(input int i);
    if (e_cnt[i] < SATV) e_cnt[i]++;
  endtask

  // q_full is raised in the cycle the DUT decides on beat full_at (one cycle after it is driven)
  task automatic step(input bit v, input bit last, input bit user, input bit en, input int idx);
    @(posedge clk); #1;
    bus.q_full   = (full_at >= 0 && prev_idx == full_at);
    bus.s_tvalid = v;
    bus.s_tlast  = last;
    bus.s_tuser  = user;
    rx_enable    = en;
    bus.s_tdata  = $urandom;
    bus.s_tkeep  = KW'($urandom);
    if (v) frame.push_back({last, bus.s_tkeep, bus.s_tdata});
    prev_idx = idx;
  endtask

  task automatic model(input int len, input bit user, input bit en, input int fa);
    if (!en) begin bump(4); return; end
    for (int k = 0; k < len; k++) begin
      if (k == fa) begin bump(2); e_wr += k; e_er++; return; end
      if (k == len - 1) begin
        if (user) begin bump(1); e_wr += k; e_er++; end
        else begin
          bump(0); e_wr += len; e_cf++;
          foreach (frame[i]) exp_q.push_back(frame[i]);
        end
        return;
      end
      if (k == MW - 1) begin bump(3); e_wr += k; e_er++; return; end
    end
  endtask

  task automatic send_frame(input int len, input bit user, input bit en0, input bit en1, input int fa, input bit gaps);
    frame.delete();
    full_at = fa;
    for (int k = 0; k < len; k++) begin
      while (gaps && $urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'b0, rx_enable, -1);
      step(1'b1, k == len - 1, (k == len - 1) ? user : 1'($urandom), (k == 0) ? en0 : en1, k);
    end
    step(1'b0, 1'b0, 1'b0, rx_enable, -1);
    step(1'b0, 1'b0, 1'b0, rx_enable, -1);
    full_at = -1;
    model(len, user, en0, fa);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".good"}, cnt_good, e_cnt[0]);
    chk({tag, ".err"}, cnt_err, e_cnt[1]);
    chk({tag, ".ovf"}, cnt_ovf, e_cnt[2]);
    chk({tag, ".oversize"}, cnt_oversize, e_cnt[3]);
    chk({tag, ".disabled"}, cnt_disabled, e_cnt[4]);
    chk({tag, ".writes"}, n_wr, e_wr);
    chk({tag, ".erases"}, n_er, e_er);
    chk({tag, ".confirms"}, n_cf, e_cf);
    chk({tag, ".violations"}, n_viol, 0);
  endtask

  initial begin
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.s_tuser = 1'b0;
    bus.s_tdata = '0; bus.s_tkeep = '0; bus.q_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rstn = 1'b1;
    send_frame(3, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    check_all("good3");
    send_frame(2, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    check_all("err2");
    send_frame(2, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    check_all("after_err");
    send_frame(4, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    check_all("ovf4");
    send_frame(1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    check_all("after_ovf");
    send_frame(MW, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    check_all("max_len");
    send_frame(MW + 2, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    check_all("oversize");
    send_frame(3, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    check_all("disabled");
    send_frame(2, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    check_all("after_dis");
    // reset lands while beat 1 of a 5-beat frame is in the input register
    frame.delete();
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1);
    @(posedge clk); #1;
    rstn = 1'b0; bus.s_tvalid = 1'b0; prev_idx = -1;
    #2 chk("write_in_reset", bus.q_write, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #2 chk("strobes_after_reset", {bus.q_write, bus.q_confirm, bus.q_erase}, 0);
    e_wr += 1;
    for (int i = 0; i < 5; i++) e_cnt[i] = 0;
    check_all("mid_reset");
    send_frame(3, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    check_all("after_reset");
    for (int n = 0; n < 40; n++) begin
      int len;
      len = $urandom_range(1, 6);
      send_frame(len, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0, 1'($urandom),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1, 1'b1);
    end
    check_all("random");
    for (int n = 0; n < SATV + 1; n++) send_frame(1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    check_all("saturate");
    chk("good_saturated", cnt_good, SATV);
    chk("committed_len", got.size(), exp_q.size());
    if (got.size() == exp_q.size())
      foreach (exp_q[i]) chk($sformatf("committed[%0d]", i), got[i], exp_q[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
